// File: rtl/mmu_sequencer.sv
// mmu_sequencer
//   Operand store and schedule controller for a 2x2 systolic MAC array.
//   A/B elements arrive one byte at a time on the load port; once all eight
//   have been written the block clears the array, feeds its left/top edges
//   with skewed operands, waits for the array to drain, captures the low
//   byte of each accumulator and then serves those bytes on out_data.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   load_en/load_sel_ab/      element write: sel_ab 0=A 1=B, index {row,col}
//   load_index/in_data
//   output_en/output_sel      C readout request, index {row,col}
//   c_flat                    array accumulators, C[i][j] at slice 2i+j
//   pe_clear, pe_en           array clear / advance controls
//   a_row0/1, b_col0/1        registered edge operands
//   out_data                  registered C byte (1-cycle latency)
//   busy, done, load_drop     status; load_drop flags a load ignored while busy
//
// Timing, counted from the edge N that accepts the eighth element:
//   state after edge N+k: k=0 CLEAR, k=1..3 FEED, k=4..(3+DRAIN_CYCLES) DRAIN,
//   then one CAPTURE cycle, then DONE.
module mmu_sequencer #(
    parameter int DATA_W       = 8,
    parameter int ACC_W        = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic                 load_sel_ab,
    input  logic [1:0]           load_index,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 output_en,
    input  logic [1:0]           output_sel,
    input  logic [4*ACC_W-1:0]   c_flat,
    output logic                 pe_clear,
    output logic                 pe_en,
    output logic [DATA_W-1:0]    a_row0,
    output logic [DATA_W-1:0]    a_row1,
    output logic [DATA_W-1:0]    b_col0,
    output logic [DATA_W-1:0]    b_col1,
    output logic [DATA_W-1:0]    out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 load_drop
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_CAPTURE, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;      // FEED step / DRAIN count
    logic [7:0]              mask_q, mask_d;
    logic [3:0][DATA_W-1:0]  a_q, b_q, c_q;
    logic [DATA_W-1:0]       out_q;

    // Edge outputs are registered from the next state so they only move on
    // state/step transitions.
    logic                    pe_clear_q, pe_clear_d;
    logic                    pe_en_q, pe_en_d;
    logic [DATA_W-1:0]       a0_q, a1_q, b0_q, b1_q;
    logic [DATA_W-1:0]       a0_d, a1_d, b0_d, b1_d;

    logic                    wr_acc;
    logic [7:0]              wr_bit;

    assign busy      = (state_q == S_CLEAR) || (state_q == S_FEED) ||
                       (state_q == S_DRAIN) || (state_q == S_CAPTURE);
    assign done      = (state_q == S_DONE);
    assign load_drop = load_en && busy;

    assign pe_clear = pe_clear_q;
    assign pe_en    = pe_en_q;
    assign a_row0   = a0_q;
    assign a_row1   = a1_q;
    assign b_col0   = b0_q;
    assign b_col1   = b1_q;
    assign out_data = out_q;

    always_comb begin
        wr_acc  = load_en && ((state_q == S_IDLE) || (state_q == S_DONE));
        wr_bit  = 8'd1 << {load_sel_ab, load_index};
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = wr_acc ? (mask_q | wr_bit) : mask_q;

        case (state_q)
            S_IDLE: begin
                // The mask check includes this cycle's write.
                if (mask_d == 8'hFF) begin
                    mask_d  = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == 8'd2) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 8'(DRAIN_CYCLES - 1)) state_d = S_CAPTURE;
                else                               cnt_d   = cnt_q + 8'd1;
            end
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    if (wr_acc) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Skewed edge feed: a_row_i = A[i][t-i], b_col_j = B[t-j][j].
        pe_clear_d = (state_d == S_CLEAR);
        pe_en_d    = (state_d == S_FEED) || (state_d == S_DRAIN);
        a0_d = '0;
        a1_d = '0;
        b0_d = '0;
        b1_d = '0;
        if (state_d == S_FEED) begin
            case (cnt_d[1:0])
                2'd0: begin
                    a0_d = a_q[0];
                    b0_d = b_q[0];
                end
                2'd1: begin
                    a0_d = a_q[1];
                    a1_d = a_q[2];
                    b0_d = b_q[2];
                    b1_d = b_q[1];
                end
                default: begin
                    a1_d = a_q[3];
                    b1_d = b_q[3];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            out_q      <= '0;
            pe_clear_q <= 1'b0;
            pe_en_q    <= 1'b0;
            a0_q       <= '0;
            a1_q       <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            pe_clear_q <= pe_clear_d;
            pe_en_q    <= pe_en_d;
            a0_q       <= a0_d;
            a1_q       <= a1_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            if (wr_acc) begin
                if (load_sel_ab) b_q[load_index] <= in_data;
                else             a_q[load_index] <= in_data;
            end
            if (state_q == S_CAPTURE) begin
                for (int k = 0; k < 4; k++)
                    c_q[k] <= c_flat[k*ACC_W +: DATA_W];   // low byte only
            end
            out_q <= output_en ? c_q[output_sel] : '0;
        end
    end

endmodule

// File: tb/tb_mmu_sequencer.sv
module tb_mmu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic        load_sel_ab = 1'b0;
    logic [1:0]  load_index = '0;
    logic [7:0]  in_data = '0;
    logic        output_en = 1'b0;
    logic [1:0]  output_sel = '0;
    logic [63:0] c_flat;
    logic        pe_clear, pe_en, busy, done, load_drop;
    logic [7:0]  a_row0, a_row1, b_col0, b_col1, out_data;

    int checks = 0;
    int failures = 0;

    mmu_sequencer dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_sel_ab(load_sel_ab),
        .load_index(load_index), .in_data(in_data), .output_en(output_en),
        .output_sel(output_sel), .c_flat(c_flat), .pe_clear(pe_clear),
        .pe_en(pe_en), .a_row0(a_row0), .a_row1(a_row1), .b_col0(b_col0),
        .b_col1(b_col1), .out_data(out_data), .busy(busy), .done(done),
        .load_drop(load_drop)
    );

    always #5 clk = ~clk;

    // Behavioural 2x2 output-stationary systolic array.
    logic [15:0] acc [4];
    logic [7:0]  af [2];
    logic [7:0]  bf [2];
    always @(posedge clk) begin
        if (pe_clear) begin
            for (int k = 0; k < 4; k++) acc[k] <= '0;
            af[0] <= '0; af[1] <= '0; bf[0] <= '0; bf[1] <= '0;
        end else if (pe_en) begin
            acc[0] <= acc[0] + 16'(a_row0) * 16'(b_col0);
            acc[1] <= acc[1] + 16'(af[0])  * 16'(b_col1);
            acc[2] <= acc[2] + 16'(a_row1) * 16'(bf[0]);
            acc[3] <= acc[3] + 16'(af[1])  * 16'(bf[1]);
            af[0] <= a_row0; af[1] <= a_row1;
            bf[0] <= b_col0; bf[1] <= b_col1;
        end
    end
    assign c_flat = {acc[3], acc[2], acc[1], acc[0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic ab, input logic [1:0] idx, input logic [7:0] d);
        load_en = 1'b1; load_sel_ab = ab; load_index = idx; in_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        output_en = 1'b1; output_sel = sel;
        tick();
        chk(tag, out_data, exp);
    endtask

    // Loads A=[1,2;3,4], B=[5,6;7,8]; returns right after the 8th write edge.
    task automatic load_std();
        ld(0, 0, 1); ld(0, 1, 2); ld(0, 2, 3); ld(0, 3, 4);
        ld(1, 0, 5); ld(1, 1, 6); ld(1, 2, 7); ld(1, 3, 8);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pe_en", pe_en, 0);
        chk("rst_pe_clear", pe_clear, 0);
        chk("rst_a_row0", a_row0, 0);
        rd("rst_out", 2'd3, 8'd0);

        // Standard multiply with schedule checks (k = edges after last load)
        load_std();
        chk("k0_pe_clear", pe_clear, 1);
        chk("k0_busy", busy, 1);
        chk("k0_pe_en", pe_en, 0);
        tick();
        chk("t0_pe_en", pe_en, 1);
        chk("t0_edges", {a_row0, a_row1, b_col0, b_col1}, {8'd1, 8'd0, 8'd5, 8'd0});
        tick();
        chk("t1_edges", {a_row0, a_row1, b_col0, b_col1}, {8'd2, 8'd3, 8'd7, 8'd6});
        tick();
        chk("t2_edges", {a_row0, a_row1, b_col0, b_col1}, {8'd0, 8'd4, 8'd0, 8'd8});
        tick();
        chk("drain_pe_en", pe_en, 1);
        chk("drain_edges", {a_row0, a_row1, b_col0, b_col1}, 32'd0);
        tick(); tick();
        chk("k6_done", done, 0);
        chk("k6_busy", busy, 1);
        tick();
        chk("k7_done", done, 1);
        chk("k7_busy", busy, 0);
        rd("c00", 2'd0, 8'd19);
        rd("c01", 2'd1, 8'd22);
        rd("c10", 2'd2, 8'd43);
        rd("c11", 2'd3, 8'd50);

        // DONE: output_en low clears out_data; a write leaves DONE
        output_en = 1'b0;
        tick();
        chk("done_oe0_out", out_data, 0);
        chk("done_hold", done, 1);
        ld(0, 0, 7);
        chk("done_fall", done, 0);
        chk("idle_busy", busy, 0);
        rd("old_c11", 2'd3, 8'd50);

        // A00 rewritten to 9; only 7 distinct elements so far -> no start
        ld(0, 0, 9); ld(0, 1, 2); ld(0, 2, 3); ld(0, 3, 4);
        ld(1, 0, 5); ld(1, 1, 6); ld(1, 2, 7);
        tick();
        chk("no_start_busy", busy, 0);
        ld(1, 3, 8);
        chk("start_pe_clear", pe_clear, 1);
        tick();
        // FEED t0: a load attempt must be dropped
        chk("rw_a_row0", a_row0, 9);
        load_en = 1'b1; load_sel_ab = 1'b0; load_index = 2'd0; in_data = 8'hFF;
        #1;
        chk("load_drop", load_drop, 1);
        tick();
        load_en = 1'b0;
        #1;
        chk("load_drop_fall", load_drop, 0);
        chk("drop_t1_a_row0", a_row0, 2);
        repeat (5) tick();
        chk("rw_done", done, 1);
        rd("rw_c00", 2'd0, 8'd59);
        rd("rw_c01", 2'd1, 8'd70);
        rd("rw_c11", 2'd3, 8'd50);

        // Reset during DRAIN
        load_std();
        repeat (4) tick();
        chk("pre_rst_drain", pe_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_pe_en", pe_en, 0);
        chk("arst_pe_clear", pe_clear, 0);
        rd("arst_c_clr", 2'd3, 8'd0);
        ld(0, 0, 1); ld(0, 1, 2); ld(0, 2, 3); ld(0, 3, 4);
        ld(1, 0, 5); ld(1, 1, 6); ld(1, 2, 7);
        chk("arst_mask_partial", busy, 0);
        ld(1, 3, 8);
        chk("fresh_start", pe_clear, 1);
        repeat (7) tick();
        chk("fresh_done", done, 1);
        rd("fresh_c00", 2'd0, 8'd19);
        rd("fresh_c11", 2'd3, 8'd50);

        // All 16s -> 512 per element, low byte 0
        for (int k = 0; k < 4; k++) ld(0, 2'(k), 8'd16);
        for (int k = 0; k < 4; k++) ld(1, 2'(k), 8'd16);
        repeat (7) tick();
        chk("big_done", done, 1);
        chk("big_model_acc11", acc[3], 512);
        rd("big_c00", 2'd0, 8'd0);
        rd("big_c11", 2'd3, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
